// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: exception codes, exception-bus bit positions,
// memory-control field positions and load-size encodings.
package mem_stage_pkg;

  localparam int unsigned RF_COLLECT_W = 38;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  // Exception bus {ale, adef, ine, syscall, break, int, ertn}
  localparam int unsigned EXC_ALE  = 6;
  localparam int unsigned EXC_ADEF = 5;
  localparam int unsigned EXC_INE  = 4;
  localparam int unsigned EXC_SYS  = 3;
  localparam int unsigned EXC_BRK  = 2;
  localparam int unsigned EXC_INT  = 1;
  localparam int unsigned EXC_ERTN = 0;

  // Memory control {req_issued, res_from_mem, ld_sign, ld_size[1:0]}
  localparam int unsigned CTRL_REQ     = 4;
  localparam int unsigned CTRL_RES_MEM = 3;
  localparam int unsigned CTRL_SIGN    = 2;

  typedef enum logic [1:0] {
    LdByte = 2'b00,
    LdHalf = 2'b01,
    LdWord = 2'b10
  } ld_size_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment: selects byte/half/word at the address offset and extends.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [31:0] sh;

  assign sh = raw >> {offset, 3'b000};

  always_comb begin
    data = sh;
    case (ld_size_e'(size))
      LdByte:  data = {{24{sign & sh[7]}}, sh[7:0]};
      LdHalf:  data = {{16{sign & sh[15]}}, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data-SRAM response, aligns load
// data and hands the result to WB. Responses owed to flushed instructions are discarded.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned EXC_W = 7,
  parameter int unsigned CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    es_to_ms_valid,
  output logic                    ms_allowin,
  input  logic [XLEN-1:0]         es_pc,
  input  logic [RF_COLLECT_W-1:0] es_rf_collect,
  input  logic [4:0]              es_mem_ctrl,
  input  logic [EXC_W-1:0]        es_to_ms_bus,
  input  logic [XLEN-1:0]         es_vaddr,
  input  logic                    data_sram_data_ok,
  input  logic [XLEN-1:0]         data_sram_rdata,
  input  logic                    wb_flush,
  input  logic                    ws_allowin,
  output logic                    ms_to_ws_valid,
  output logic [XLEN-1:0]         ms_pc,
  output logic [RF_COLLECT_W-1:0] ms_rf_collect,
  output logic [EXC_W-1:0]        ms_to_ws_bus,
  output logic [XLEN-1:0]         ms_vaddr,
  output logic                    ms_ex,
  output logic                    ms_load_pending
);

  logic                    ms_valid_q, ms_valid_d;
  logic [XLEN-1:0]         pc_q;
  logic [RF_COLLECT_W-1:0] rf_collect_q;
  logic [4:0]              ctrl_q;
  logic [EXC_W-1:0]        bus_q;
  logic [XLEN-1:0]         vaddr_q;
  logic                    buf_valid_q, buf_valid_d;
  logic [XLEN-1:0]         buf_q, buf_d;
  logic [CNT_W-1:0]        discard_cnt_q, discard_cnt_d;

  logic            need_data;
  logic            resp_mine;
  logic            ms_ready_go;
  logic            to_wb;
  logic            load_payload;
  logic            buf_latch;
  logic            cnt_inc;
  logic            cnt_dec;
  logic [XLEN-1:0] raw_data;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wdata;

  assign need_data    = ms_valid_q & ctrl_q[CTRL_REQ];
  // A response only belongs to us once every stale one has been swallowed.
  assign resp_mine    = data_sram_data_ok & (discard_cnt_q == '0);
  assign ms_ready_go  = ~need_data | buf_valid_q | resp_mine;
  assign ms_allowin   = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~wb_flush;
  assign to_wb        = ms_to_ws_valid & ws_allowin;
  assign load_payload = es_to_ms_valid & ms_allowin & ~wb_flush;
  assign buf_latch    = resp_mine & need_data & ~buf_valid_q & ~ws_allowin;
  assign cnt_inc      = wb_flush & need_data & ~buf_valid_q & ~resp_mine;
  assign cnt_dec      = data_sram_data_ok & (discard_cnt_q != '0);

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    if (wb_flush || to_wb) begin
      buf_valid_d = 1'b0;
    end else if (buf_latch) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end

    discard_cnt_d = discard_cnt_q;
    if (cnt_inc && !cnt_dec && (discard_cnt_q != {CNT_W{1'b1}})) begin
      discard_cnt_d = discard_cnt_q + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      discard_cnt_d = discard_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      pc_q          <= '0;
      rf_collect_q  <= '0;
      ctrl_q        <= '0;
      bus_q         <= '0;
      vaddr_q       <= '0;
      buf_valid_q   <= 1'b0;
      buf_q         <= '0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      buf_valid_q   <= buf_valid_d;
      buf_q         <= buf_d;
      discard_cnt_q <= discard_cnt_d;
      if (load_payload) begin
        pc_q         <= es_pc;
        rf_collect_q <= es_rf_collect;
        ctrl_q       <= es_mem_ctrl;
        bus_q        <= es_to_ms_bus;
        vaddr_q      <= es_vaddr;
      end
    end
  end

  assign raw_data = buf_valid_q ? buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .raw    (raw_data),
    .offset (vaddr_q[1:0]),
    .size   (ctrl_q[1:0]),
    .sign   (ctrl_q[CTRL_SIGN]),
    .data   (ld_data)
  );

  assign wdata           = ctrl_q[CTRL_RES_MEM] ? ld_data : rf_collect_q[XLEN-1:0];
  assign ms_pc           = pc_q;
  assign ms_rf_collect   = {rf_collect_q[RF_COLLECT_W-1:XLEN], wdata};
  assign ms_to_ws_bus    = bus_q;
  assign ms_vaddr        = vaddr_q;
  assign ms_ex           = ms_valid_q & (|bus_q);
  assign ms_load_pending = ms_valid_q & ctrl_q[CTRL_RES_MEM] & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic against an
// in-order instruction/response reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [37:0] es_rf_collect;
  logic [4:0]  es_mem_ctrl;
  logic [6:0]  es_to_ms_bus;
  logic [31:0] es_vaddr;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_flush;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_collect;
  logic [6:0]  ms_to_ws_bus;
  logic [31:0] ms_vaddr;
  logic        ms_ex;
  logic        ms_load_pending;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_rf_collect     (es_rf_collect),
    .es_mem_ctrl       (es_mem_ctrl),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_vaddr          (es_vaddr),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_flush          (wb_flush),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_collect     (ms_rf_collect),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_vaddr          (ms_vaddr),
    .ms_ex             (ms_ex),
    .ms_load_pending   (ms_load_pending)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [37:0] rf;
    logic [4:0]  ctrl;
    logic [6:0]  bus;
    logic [31:0] vaddr;
    logic [31:0] rdata;
    int          delay;
    bit          seen;
    bit          has_exp;
    logic [31:0] exp_wdata;
  } instr_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } resp_t;

  instr_t inflight[$];
  instr_t script[$];
  resp_t  resp_q[$];
  instr_t ex_instr;
  bit     ex_valid;

  int checks;
  int failures;
  int cyc;
  int next_id;
  int wb_count;
  int p_issue, p_ws, p_flush, dmax;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference load result from the architectural rule, by plain arithmetic.
  function automatic logic [31:0] ld_ref(logic [31:0] raw, logic [1:0] off, logic [1:0] size,
                                         logic sign);
    int unsigned s;
    int unsigned v;
    s = raw >> (8 * off);
    case (size)
      2'd0: begin
        v = s % 256;
        if (sign && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = s % 65536;
        if (sign && v >= 32768) v = v - 65536;
      end
      default: v = s;
    endcase
    return v;
  endfunction

  function automatic instr_t mk(logic [4:0] ctrl, logic [31:0] vaddr, logic [31:0] rdata,
                                logic [6:0] bus, int delay);
    instr_t t;
    t.id        = 0;
    t.pc        = $urandom & 32'hFFFF_FFFC;
    t.rf        = {6'($urandom), 32'($urandom)};
    t.ctrl      = ctrl;
    t.bus       = bus;
    t.vaddr     = vaddr;
    t.rdata     = rdata;
    t.delay     = delay;
    t.seen      = 1'b0;
    t.has_exp   = 1'b0;
    t.exp_wdata = '0;
    return t;
  endfunction

  function automatic instr_t gen_rand();
    int          k;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] base;
    logic        sg;
    k    = $urandom_range(0, 9);
    base = $urandom & 32'hFFFF_FFFC;
    sz   = 2'($urandom_range(0, 2));
    sg   = 1'($urandom_range(0, 1));
    off  = (sz == 2'd0) ? 2'($urandom_range(0, 3)) :
           (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
    if (k <= 2) return mk({2'b00, sg, sz}, base | 32'(off), $urandom, 7'd0, 0);
    if (k <= 6) return mk({2'b11, sg, sz}, base | 32'(off), $urandom, 7'd0,
                          $urandom_range(0, dmax));
    if (k <= 8) return mk({2'b10, sg, sz}, base | 32'(off), $urandom, 7'd0,
                          $urandom_range(0, dmax));
    return mk(5'b00000, base, $urandom, 7'($urandom_range(1, 127)), 0);
  endfunction

  task automatic push_script(input logic [4:0] ctrl, input logic [31:0] vaddr,
                             input logic [31:0] rdata, input logic [6:0] bus, input int delay,
                             input bit has_exp, input logic [31:0] exp_w);
    instr_t t;
    t           = mk(ctrl, vaddr, rdata, bus, delay);
    t.has_exp   = has_exp;
    t.exp_wdata = exp_w;
    script.push_back(t);
  endtask

  // One clock: drive at posedge+1, evaluate at negedge, update the model for the next edge.
  task automatic cycle();
    bit          valid, ready, ok_mine, exp_allow, exp_tows, hs_wb, accept;
    instr_t      f;
    resp_t       r;
    logic [31:0] exp_w;
    ws_allowin = ($urandom_range(0, 99) < p_ws);
    wb_flush   = ($urandom_range(0, 99) < p_flush) && (resp_q.size() < 3);
    if (!ex_valid) begin
      if (script.size() != 0) begin
        ex_instr = script.pop_front();
        ex_valid = 1'b1;
      end else if ($urandom_range(0, 99) < p_issue) begin
        ex_instr = gen_rand();
        ex_valid = 1'b1;
      end
      if (ex_valid) begin
        ex_instr.id = next_id;
        next_id++;
      end
    end
    es_to_ms_valid = ex_valid;
    es_pc          = ex_instr.pc;
    es_rf_collect  = ex_instr.rf;
    es_mem_ctrl    = ex_instr.ctrl;
    es_to_ms_bus   = ex_instr.bus;
    es_vaddr       = ex_instr.vaddr;
    if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = resp_q[0].data;
    end else begin
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
    end

    @(negedge clk);
    f     = mk(5'd0, 32'd0, 32'd0, 7'd0, 0);
    valid = (inflight.size() != 0);
    if (valid) f = inflight[0];
    ok_mine   = data_sram_data_ok && valid && (resp_q[0].id == f.id);
    ready     = !f.ctrl[4] || f.seen || ok_mine;
    exp_allow = !valid || (ready && ws_allowin);
    exp_tows  = valid && ready && !wb_flush;
    check("ms_allowin", ms_allowin, exp_allow);
    check("ms_to_ws_valid", ms_to_ws_valid, exp_tows);
    check("ms_ex", ms_ex, valid && (f.bus != 7'd0));
    check("ms_load_pending", ms_load_pending, valid && f.ctrl[3] && !ready);
    hs_wb  = exp_tows && ws_allowin;
    accept = ex_valid && exp_allow && !wb_flush;

    if (hs_wb) begin
      exp_w = f.ctrl[3] ? ld_ref(f.rdata, f.vaddr[1:0], f.ctrl[1:0], f.ctrl[2]) : f.rf[31:0];
      check("wb_pc", ms_pc, f.pc);
      check("wb_rf_collect", ms_rf_collect, {f.rf[37:32], exp_w});
      check("wb_bus", ms_to_ws_bus, f.bus);
      check("wb_vaddr", ms_vaddr, f.vaddr);
      if (f.has_exp) check("wb_wdata_literal", ms_rf_collect[31:0], f.exp_wdata);
      wb_count++;
    end
    if (data_sram_data_ok) begin
      if (ok_mine) inflight[0].seen = 1'b1;
      void'(resp_q.pop_front());
    end
    if (wb_flush) begin
      inflight.delete();
      ex_valid = 1'b0;
    end else begin
      if (hs_wb) void'(inflight.pop_front());
      if (accept) begin
        inflight.push_back(ex_instr);
        if (ex_instr.ctrl[4]) begin
          r.id   = ex_instr.id;
          r.data = ex_instr.rdata;
          r.due  = cyc + 1 + ex_instr.delay;
          resp_q.push_back(r);
        end
        ex_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    bit busy;
    p_issue = 0;
    p_flush = 0;
    p_ws    = 100;
    busy    = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      busy = (inflight.size() != 0) || (resp_q.size() != 0) || ex_valid || (script.size() != 0);
      if (busy) cycle();
    end
    busy = (inflight.size() != 0) || (resp_q.size() != 0) || ex_valid || (script.size() != 0);
    check("drain_done", busy, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    wb_flush          = 1'b0;
    ws_allowin        = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    inflight.delete();
    resp_q.delete();
    script.delete();
    ex_valid = 1'b0;
    check({tag, "_allowin"}, ms_allowin, 1'b1);
    check({tag, "_to_ws_valid"}, ms_to_ws_valid, 1'b0);
    check({tag, "_pc"}, ms_pc, 32'd0);
    check({tag, "_rf"}, ms_rf_collect, 38'd0);
    check({tag, "_bus"}, ms_to_ws_bus, 7'd0);
    check({tag, "_vaddr"}, ms_vaddr, 32'd0);
    check({tag, "_ex"}, ms_ex, 1'b0);
    check({tag, "_pending"}, ms_load_pending, 1'b0);
    check({tag, "_discard_cnt"}, dut.discard_cnt_q, 2'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    next_id  = 1;
    wb_count = 0;
    ex_valid = 1'b0;
    ex_instr = mk(5'd0, 32'd0, 32'd0, 7'd0, 0);
    es_pc = '0; es_rf_collect = '0; es_mem_ctrl = '0; es_to_ms_bus = '0; es_vaddr = '0;
    data_sram_rdata = '0;
    p_issue = 0; p_ws = 100; p_flush = 0; dmax = 4;
    reset = 1'b1;
    @(posedge clk);
    do_reset("reset");

    // ld.b at offset 3, response two cycles late.
    push_script(5'b11100, 32'h0000_1003, 32'h80FF_1234, 7'd0, 2, 1'b1, 32'hFFFF_FF80);
    drain();
    // ld.hu at offset 2.
    push_script(5'b11001, 32'h0000_2002, 32'h8001_0000, 7'd0, 0, 1'b1, 32'h0000_8001);
    drain();

    // Flush while a load waits; its late response must be discarded.
    push_script(5'b11110, 32'h0000_3000, 32'hDEAD_BEEF, 7'd0, 6, 1'b0, 32'd0);
    run_cycles(3);
    p_flush = 100;
    run_cycles(1);
    p_flush = 0;
    check("flush_discard_cnt", dut.discard_cnt_q, 2'd1);
    push_script(5'b11110, 32'h0000_3100, 32'h0BAD_F00D, 7'd0, 0, 1'b1, 32'h0BAD_F00D);
    run_cycles(12);
    check("flush_discard_cnt_end", dut.discard_cnt_q, 2'd0);
    drain();

    // Response arrives while WB stalls; buffered data delivered later.
    p_ws = 0;
    push_script(5'b11110, 32'h0000_4000, 32'h1234_5678, 7'd0, 0, 1'b1, 32'h1234_5678);
    run_cycles(5);
    p_ws = 100;
    run_cycles(3);
    drain();

    // adef passes through, no wait on data_ok.
    push_script(5'b00000, 32'h0000_5001, 32'h0, 7'b0100000, 0, 1'b0, 32'd0);
    run_cycles(3);
    drain();

    // Reset mid-wait with a pending discard.
    push_script(5'b11110, 32'h0000_6000, 32'hCAFE_0001, 7'd0, 20, 1'b0, 32'd0);
    run_cycles(3);
    p_flush = 100;
    run_cycles(1);
    p_flush = 0;
    push_script(5'b11110, 32'h0000_6100, 32'hCAFE_0002, 7'd0, 20, 1'b0, 32'd0);
    run_cycles(3);
    do_reset("midwait");

    // Randomized traffic.
    p_issue = 60;
    p_ws    = 70;
    p_flush = 5;
    dmax    = 4;
    run_cycles(4000);
    drain();
    check("final_discard_cnt", dut.discard_cnt_q, 2'd0);
    check("wb_count_sane", wb_count > 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
